// File: rtl/mul_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_alu                                                      |
// | Description : EX-stage ALU. Add/sub/and/or finish in one cycle; multiply   |
// |               is an iterative shift-add sequence with a valid/ready/done   |
// |               handshake. Optional macro: MUL_EARLY_EXIT_EN.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [3:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic [WIDTH-1:0] data_o,
   output logic             zero_o,
   output logic             done_o
);

   localparam int             c_cnt_w   = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   localparam logic [3:0] c_op_and = 4'b0000;
   localparam logic [3:0] c_op_or  = 4'b0001;
   localparam logic [3:0] c_op_add = 4'b0010;
   localparam logic [3:0] c_op_mul = 4'b0011;
   localparam logic [3:0] c_op_sub = 4'b0110;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t               r_state;
   logic                 r_ready;
   logic                 r_done;
   logic                 r_zero;
   logic [WIDTH-1:0]     r_data;
   logic [WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [c_cnt_w-1:0]   r_count;

   logic                 w_accept;
   logic                 w_mul_finish;
   logic [WIDTH-1:0]     w_alu_res;

   assign w_accept = valid_i && r_ready;

   always_comb begin
      w_alu_res = data1_i + data2_i;
      case (ALUCtrl_i)
         c_op_and: w_alu_res = data1_i & data2_i;
         c_op_or:  w_alu_res = data1_i | data2_i;
         c_op_sub: w_alu_res = data1_i - data2_i;
         default:  w_alu_res = data1_i + data2_i;
      endcase
   end

`ifdef MUL_EARLY_EXIT_EN
   // Stop once every remaining multiplier bit is zero, but always run one step.
   assign w_mul_finish = (r_count == c_cnt_last) ||
                         ((r_mplier == '0) && (r_count != '0));
`else
   assign w_mul_finish = (r_count == c_cnt_last);
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state  <= S_IDLE;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_zero   <= 1'b1;
         r_data   <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (ALUCtrl_i == c_op_mul) begin
                     r_state  <= S_MUL;
                     r_ready  <= 1'b0;
                     r_acc    <= '0;
                     r_mcand  <= data1_i;
                     r_mplier <= data2_i;
                     r_count  <= '0;
                  end else begin
                     r_data <= w_alu_res;
                     r_zero <= (w_alu_res == '0);
                     r_done <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               // The write-back edge comes one edge after the last shift-add step.
               if (w_mul_finish) begin
                  r_data  <= r_acc;
                  r_zero  <= (r_acc == '0);
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  if (r_mplier[0]) begin
                     r_acc <= r_acc + r_mcand;
                  end
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_count  <= r_count + c_cnt_one;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready_o = r_ready;
   assign done_o  = r_done;
   assign data_o  = r_data;
   assign zero_o  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_mul_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_alu                                                   |
// | Description : Self-checking bench for mul_alu (directed + random ops).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mul_alu;

   localparam int WIDTH = 32;

   logic             clk_i;
   logic             rst_i;
   logic             valid_i;
   logic             ready_o;
   logic [3:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic [WIDTH-1:0] data_o;
   logic             zero_o;
   logic             done_o;

   int n_assert = 0;
   int n_fail   = 0;

   mul_alu #(.WIDTH(WIDTH)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .ALUCtrl_i (ALUCtrl_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .data_o    (data_o),
      .zero_o    (zero_o),
      .done_o    (done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: what the operation means arithmetically.
   function automatic logic [31:0] model(input logic [3:0] ctrl, input logic [31:0] a,
                                         input logic [31:0] b);
      longint unsigned p;
      case (ctrl)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0110: return a - b;
         4'b0011: begin
            p = longint'(a) * longint'(b);
            return p[31:0];
         end
         default: return a + b;
      endcase
   endfunction

   // Edges from the accept edge to the edge after which done_o is seen.
   function automatic int exp_lat(input logic [3:0] ctrl, input logic [31:0] b);
      int k;
      if (ctrl != 4'b0011) return 0;
`ifdef MUL_EARLY_EXIT_EN
      k = 0;
      while (k < 32 && (b >> k) != 0) k++;
      return ((k < 1) ? 1 : k) + 1;
`else
      return WIDTH + 1;
`endif
   endfunction

   task automatic run_op(input string tag, input logic [3:0] ctrl,
                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      logic [31:0] prev;
      int          edges;
      bit          busy_bad;
      exp      = model(ctrl, a, b);
      busy_bad = 1'b0;
      @(negedge clk_i);
      prev      = data_o;
      ALUCtrl_i = ctrl;
      data1_i   = a;
      data2_i   = b;
      valid_i   = 1'b1;
      check({tag, "_ready_in"}, {31'b0, ready_o}, 32'd1);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      edges   = 0;
      while (!done_o && edges < 100) begin
         if (ready_o || data_o !== prev) busy_bad = 1'b1;
         @(posedge clk_i);
         #1;
         edges++;
      end
      check({tag, "_latency"}, edges, exp_lat(ctrl, b));
      check({tag, "_data"}, data_o, exp);
      check({tag, "_zero"}, {31'b0, zero_o}, {31'b0, exp == 32'd0});
      check({tag, "_ready_done"}, {31'b0, ready_o}, 32'd1);
      if (ctrl == 4'b0011) check({tag, "_busy_hold"}, {31'b0, busy_bad}, 32'd0);
   endtask

   initial begin : stimulus
      logic [3:0]  codes [6];
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] held;
      int          edges;
      bit          busy_bad;
      bit          seen_done;

      rst_i     = 1'b0;
      valid_i   = 1'b0;
      ALUCtrl_i = 4'b0;
      data1_i   = '0;
      data2_i   = '0;

      // Reset held for two edges
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_data",  data_o, 32'd0);
      check("rst_zero",  {31'b0, zero_o},  32'd1);
      check("rst_done",  {31'b0, done_o},  32'd0);
      check("rst_ready", {31'b0, ready_o}, 32'd1);
      rst_i = 1'b1;

      // Back-to-back add/sub
      run_op("add_5_7", 4'b0010, 32'd5, 32'd7);
      run_op("sub_7_7", 4'b0110, 32'd7, 32'd7);
      run_op("sub_0_1", 4'b0110, 32'd0, 32'd1);
      @(posedge clk_i);
      #1;
      check("done_falls", {31'b0, done_o}, 32'd0);
      check("data_holds", data_o, 32'hFFFF_FFFF);

      // Logic and default code
      run_op("and",     4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
      run_op("or",      4'b0001, 32'h0000_F0F0, 32'h0000_FF00);
      run_op("dflt_f",  4'b1111, 32'd2, 32'd3);

      // Multiply pair 1
      run_op("mul1", 4'b0011, 32'h0001_0001, 32'h0001_0001);

      // Multiply pair 2 with an add request raised while busy
      @(negedge clk_i);
      held      = data_o;
      ALUCtrl_i = 4'b0011;
      data1_i   = 32'hFFFF_FFFD;
      data2_i   = 32'd7;
      valid_i   = 1'b1;
      @(posedge clk_i);
      #1;
      ALUCtrl_i = 4'b0010;
      data1_i   = 32'd10;
      data2_i   = 32'd20;
      edges     = 0;
      busy_bad  = 1'b0;
      while (!done_o && edges < 100) begin
         if (ready_o || data_o !== held) busy_bad = 1'b1;
         @(posedge clk_i);
         #1;
         edges++;
      end
      check("mul2_latency", edges, exp_lat(4'b0011, 32'd7));
      check("mul2_data", data_o, 32'hFFFF_FFEB);
      check("mul2_busy", {31'b0, busy_bad}, 32'd0);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      check("busy_add_done", {31'b0, done_o}, 32'd1);
      check("busy_add_data", data_o, 32'd30);

      // Early-exit operands (full latency without the macro)
      run_op("mul_100x3", 4'b0011, 32'd100, 32'd3);
      run_op("mul_x0",    4'b0011, 32'h0000_1234, 32'd0);

      // Reset in the middle of a multiply
      @(negedge clk_i);
      ALUCtrl_i = 4'b0011;
      data1_i   = 32'h0000_00FF;
      data2_i   = 32'hFFFF_FFFF;
      valid_i   = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      repeat (9) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("abort_data",  data_o, 32'd0);
      check("abort_zero",  {31'b0, zero_o},  32'd1);
      check("abort_done",  {31'b0, done_o},  32'd0);
      check("abort_ready", {31'b0, ready_o}, 32'd1);
      @(negedge clk_i);
      rst_i     = 1'b1;
      seen_done = 1'b0;
      repeat (40) begin
         @(posedge clk_i);
         #1;
         if (done_o) seen_done = 1'b1;
      end
      check("abort_no_done", {31'b0, seen_done}, 32'd0);
      run_op("post_rst_add", 4'b0010, 32'd1, 32'd1);

      // Random operations against the reference
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0011};
      for (int i = 0; i < 30; i++) begin
         c = codes[$urandom_range(0, 5)];
         if ($urandom_range(0, 5) == 0) c = 4'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 7) == 0) b = a;
         run_op($sformatf("rnd%0d", i), c, a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
